j_frame_scan_counter: RTL and testbench
=======================================

// Module: j_frame_scan_counter
// PURPOSE
//  Parametrised 2-D raster scan counter: generates (col,row) and a linear pixel address
//  for a runtime-configured image of cfg_width x cfg_height, advancing one pixel per
//  accepted 'advance'. Successor to the single-axis row counter; adds start/busy control,
//  row pitch/base addressing, last-flags, done pulses and config error detection.
//  Feeds image-buffer read/write address ports in the image pipeline.
// PARAMETERS
//  DIM_W   13  width of col/row counters and cfg_width/cfg_height (max dim 2^DIM_W-1)
//  ADDR_W  24  width of linear address, cfg_pitch, cfg_base
// PORTS
//  clk         in   1       system clock, rising edge
//  n_rst       in   1       asynchronous active-low reset
//  clear       in   1       synchronous abort: return to IDLE, zero all counters
//  start       in   1       begin frame; sampled only when busy=0
//  cfg_width   in   DIM_W   pixels per row; latched on accepted start
//  cfg_height  in   DIM_W   rows per frame; latched on accepted start
//  cfg_pitch   in   ADDR_W  address step between row starts; latched on start
//  cfg_base    in   ADDR_W  address of pixel (0,0); latched on start
//  advance     in   1       consume current pixel; ignored when busy=0
//  busy        out  1       frame in progress; col/row/addr valid
//  col         out  DIM_W   current column
//  row         out  DIM_W   current row
//  addr        out  ADDR_W  cfg_base + row*cfg_pitch + col, mod 2^ADDR_W
//  col_last    out  1       comb: busy & col==W-1
//  frame_last  out  1       comb: busy & col==W-1 & row==H-1
//  row_done    out  1       1-cycle pulse after advance at col_last
//  frame_done  out  1       1-cycle pulse after advance at frame_last
//  cfg_err     out  1       1-cycle pulse: start rejected (width or height == 0)
// BEHAVIOUR
//  Reset (n_rst=0, async): state IDLE; busy, col, row, addr, row_done, frame_done,
//   cfg_err all 0; latched config 0.
//  States: IDLE, RUN. clear has priority over start/advance in every state -> IDLE,
//   counters 0, pulses 0 next cycle.
//  IDLE: start & W!=0 & H!=0 -> RUN next cycle, col=0,row=0,addr=cfg_base,busy=1.
//   start with W==0 or H==0 -> stay IDLE, cfg_err=1 next cycle. advance ignored.
//  RUN, advance=0: all outputs hold. start ignored (no relatch, no error).
//  RUN, advance & !col_last: col+1, addr+1.
//  RUN, advance & col_last & !frame_last: col=0, row+1, addr=row_base+pitch
//   (row_base register tracks start-of-row address; no multiplier), row_done=1.
//  RUN, advance & frame_last: -> IDLE; busy=0, col=row=0, addr=0, row_done=1,
//   frame_done=1 (same cycle). Start may be accepted in that cycle (busy=0).
//  W==1: every advance is col_last. W==1,H==1: first advance ends frame.
//  Address arithmetic wraps modulo 2^ADDR_W; no overflow flag.
//  Latency: start->busy 1 cycle; advance->updated coords 1 cycle; no bubbles, so
//   advance held high scans W*H pixels in W*H consecutive cycles.
//  Config inputs may change freely while busy; only the latched copies are used.
// STRUCTURE
//  Package j_img_pkg: DIM_W/ADDR_W defaults, scan_state_t enum {IDLE, RUN}.
//  Sub-module j_axis_counter (DIM_W): clear, enable, limit -> count, last, wrap pulse;
//   instantiated twice (col: enable=advance; row: enable=advance&col_last).
//  Top holds FSM, config latches, row_base/addr accumulators, pulse registers.
// TESTING
//  W=4,H=3,pitch=8,base=0x100, advance held -> addr 100..103,108..10B,110..113;
//   row_done at cycles 4,8,12; frame_done+busy=0 at cycle 12.
//  Same frame, advance toggled 1-0 -> coords hold on 0 cycles; 24 cycles total.
//  start with W=0 (then H=0) -> cfg_err one pulse each, busy stays 0.
//  W=1,H=1 -> one advance gives row_done=frame_done=1, busy=0; restart in that cycle.
//  clear mid-frame (col=2,row=1) -> next cycle busy=0, col=row=addr=0, no done pulse.
//  n_rst asserted mid-frame -> outputs 0 immediately, async; base=0xFFFFFE,W=4 wraps addr to 0x000001.

Source files
------------

// File: rtl/j_img_pkg.sv
// Shared definitions for the image-pipeline address generators.
// Holds default counter/address widths and the raster scan state encoding.
package j_img_pkg;

    localparam int DIM_W_DEF  = 13;
    localparam int ADDR_W_DEF = 24;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_t;

endpackage : j_img_pkg

// File: rtl/j_axis_counter.sv
// Single-axis modulo counter: counts 0..limit-1 on enable and wraps to 0.
// 'wrap' flags the enabled cycle in which the counter returns to zero.
module j_axis_counter #(
    parameter int DIM_W = 13
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIM_W-1:0] limit,
    output logic [DIM_W-1:0] count,
    output logic             last,
    output logic             wrap
);

    logic [DIM_W-1:0] count_q;
    logic [DIM_W-1:0] count_d;

    assign last  = (count_q == (limit - DIM_W'(1)));
    assign wrap  = enable & last;
    assign count = count_q;

    // Next count: clear wins, then wrap-or-increment on enable
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (last) begin
                count_d = '0;
            end else begin
                count_d = count_q + DIM_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : j_axis_counter

// File: rtl/j_frame_scan_counter.sv
// 2-D raster scan counter producing (col,row) and a linear pixel address.
// Row starts are tracked by accumulating pitch, so no multiplier is needed.
module j_frame_scan_counter
    import j_img_pkg::*;
#(
    parameter int DIM_W  = DIM_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [ADDR_W-1:0] cfg_pitch,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              advance,
    output logic              busy,
    output logic [DIM_W-1:0]  col,
    output logic [DIM_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              col_last,
    output logic              frame_last,
    output logic              row_done,
    output logic              frame_done,
    output logic              cfg_err
);

    scan_state_t       state_q;
    scan_state_t       state_d;

    logic [DIM_W-1:0]  width_q,  width_d;
    logic [DIM_W-1:0]  height_q, height_d;
    logic [ADDR_W-1:0] pitch_q,  pitch_d;
    logic [ADDR_W-1:0] base_q,   base_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              row_done_q,   row_done_d;
    logic              frame_done_q, frame_done_d;
    logic              cfg_err_q,    cfg_err_d;

    logic              dims_ok;
    logic              start_ok;
    logic              step;
    logic              cnt_clear;
    logic              col_last_raw;
    logic              col_wrap;
    logic              row_last_raw;
    logic              row_wrap;

    assign dims_ok   = (cfg_width != DIM_W'(0)) & (cfg_height != DIM_W'(0));
    assign start_ok  = ~busy & start & dims_ok;
    assign step      = busy & advance & ~clear;
    assign cnt_clear = clear | start_ok;

    j_axis_counter #(.DIM_W(DIM_W)) u_col_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (cnt_clear),
        .enable (step),
        .limit  (width_q),
        .count  (col),
        .last   (col_last_raw),
        .wrap   (col_wrap)
    );

    // The row axis only moves when the column axis rolls over
    j_axis_counter #(.DIM_W(DIM_W)) u_row_cnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (cnt_clear),
        .enable (col_wrap),
        .limit  (height_q),
        .count  (row),
        .last   (row_last_raw),
        .wrap   (row_wrap)
    );

    assign col_last   = busy & col_last_raw;
    assign frame_last = col_last & row_last_raw;

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; clear overrides everything
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (advance & frame_last) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy = 1'b0;
        case (state_q)
            IDLE:    busy = 1'b0;
            RUN:     busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Config latch, address accumulators and pulse generation
    always_comb begin
        width_d      = width_q;
        height_d     = height_q;
        pitch_d      = pitch_q;
        base_d       = base_q;
        addr_d       = addr_q;
        row_base_d   = row_base_q;
        row_done_d   = 1'b0;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;
        if (clear) begin
            addr_d     = '0;
            row_base_d = '0;
        end else if (!busy) begin
            if (start_ok) begin
                width_d    = cfg_width;
                height_d   = cfg_height;
                pitch_d    = cfg_pitch;
                base_d     = cfg_base;
                addr_d     = cfg_base;
                row_base_d = cfg_base;
            end else begin
                cfg_err_d = start;
            end
        end else if (advance) begin
            row_done_d = col_last;
            if (frame_last) begin
                frame_done_d = 1'b1;
                addr_d       = '0;
                row_base_d   = '0;
            end else if (col_last) begin
                addr_d     = row_base_q + pitch_q;
                row_base_d = row_base_q + pitch_q;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            width_q      <= '0;
            height_q     <= '0;
            pitch_q      <= '0;
            base_q       <= '0;
            addr_q       <= '0;
            row_base_q   <= '0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            width_q      <= width_d;
            height_q     <= height_d;
            pitch_q      <= pitch_d;
            base_q       <= base_d;
            addr_q       <= addr_d;
            row_base_q   <= row_base_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign addr       = addr_q;
    assign row_done   = row_done_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;

    logic unused_row_wrap;
    assign unused_row_wrap = row_wrap;

endmodule : j_frame_scan_counter

// File: tb/tb_j_frame_scan_counter.sv
// Scoreboard bench for j_frame_scan_counter: a behavioural reference model
// (multiplying address form) queues expected outputs per driven cycle.
module tb_j_frame_scan_counter;

    localparam int DW = 13;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          clr = 1'b0, st = 1'b0, adv = 1'b0;
    logic [DW-1:0] cw = '0, ch = '0;
    logic [AW-1:0] cp = '0, cb = '0;
    logic          busy, col_last, frame_last, row_done, frame_done, cfg_err;
    logic [DW-1:0] col, row;
    logic [AW-1:0] addr;

    j_frame_scan_counter dut (
        .clk(clk), .n_rst(n_rst), .clear(clr), .start(st),
        .cfg_width(cw), .cfg_height(ch), .cfg_pitch(cp), .cfg_base(cb),
        .advance(adv), .busy(busy), .col(col), .row(row), .addr(addr),
        .col_last(col_last), .frame_last(frame_last), .row_done(row_done),
        .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          busy;
        logic [DW-1:0] col;
        logic [DW-1:0] row;
        logic [AW-1:0] addr;
        logic          cl, fl, rd, fd, err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state
    logic          m_busy = 1'b0, m_rd = 1'b0, m_fd = 1'b0, m_err = 1'b0;
    logic [DW-1:0] m_col = '0, m_row = '0, m_w = '0, m_h = '0;
    logic [AW-1:0] m_p = '0, m_b = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.busy = m_busy;
        e.col  = m_col;
        e.row  = m_row;
        e.addr = m_busy ? AW'(m_b + AW'(m_row) * m_p + AW'(m_col)) : '0;
        e.cl   = m_busy && (m_col == m_w - 13'd1);
        e.fl   = e.cl && (m_row == m_h - 13'd1);
        e.rd   = m_rd;
        e.fd   = m_fd;
        e.err  = m_err;
        return e;
    endfunction

    task automatic model_update(input logic s, a, c, input logic [DW-1:0] w, h,
                                input logic [AW-1:0] p, b);
        exp_t cur;
        cur   = model_exp();
        m_rd  = 1'b0;
        m_fd  = 1'b0;
        m_err = 1'b0;
        if (c) begin
            m_busy = 1'b0; m_col = '0; m_row = '0;
        end else if (!m_busy) begin
            if (s) begin
                if (w == 13'd0 || h == 13'd0) begin
                    m_err = 1'b1;
                end else begin
                    m_w = w; m_h = h; m_p = p; m_b = b;
                    m_busy = 1'b1; m_col = '0; m_row = '0;
                end
            end
        end else if (a) begin
            if (cur.fl) begin
                m_busy = 1'b0; m_col = '0; m_row = '0; m_rd = 1'b1; m_fd = 1'b1;
            end else if (cur.cl) begin
                m_col = '0; m_row = m_row + 13'd1; m_rd = 1'b1;
            end else begin
                m_col = m_col + 13'd1;
            end
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("busy",       32'(busy),       32'(e.busy));
            check_eq("col",        32'(col),        32'(e.col));
            check_eq("row",        32'(row),        32'(e.row));
            check_eq("addr",       32'(addr),       32'(e.addr));
            check_eq("col_last",   32'(col_last),   32'(e.cl));
            check_eq("frame_last", 32'(frame_last), 32'(e.fl));
            check_eq("row_done",   32'(row_done),   32'(e.rd));
            check_eq("frame_done", 32'(frame_done), 32'(e.fd));
            check_eq("cfg_err",    32'(cfg_err),    32'(e.err));
        end
    endtask

    task automatic step(input logic s, a, c, input logic [DW-1:0] w, h,
                        input logic [AW-1:0] p, b);
        @(negedge clk);
        st = s; adv = a; clr = c; cw = w; ch = h; cp = p; cb = b;
        model_update(s, a, c, w, h, p, b);
        sb_q.push_back(model_exp());
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_col"},  32'(col),  32'd0);
        check_eq({tag, "_row"},  32'(row),  32'd0);
        check_eq({tag, "_addr"}, 32'(addr), 32'd0);
        check_eq({tag, "_pulses"}, 32'({row_done, frame_done, cfg_err}), 32'd0);
    endtask

    logic [AW-1:0] addr_tbl [12];

    initial begin
        addr_tbl = '{24'h100, 24'h101, 24'h102, 24'h103,
                     24'h108, 24'h109, 24'h10A, 24'h10B,
                     24'h110, 24'h111, 24'h112, 24'h113};
        // reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // full frame, advance held
        step(1'b1, 1'b0, 1'b0, 13'd4, 13'd3, 24'd8, 24'h100);
        for (int i = 0; i < 12; i++) begin
            check_eq("addr_seq", 32'(addr), 32'(addr_tbl[i]));
            step(1'b0, 1'b1, 1'b0, 13'($urandom), 13'($urandom), 24'($urandom), 24'($urandom));
        end
        check_eq("frame_end_done", 32'({frame_done, busy}), 32'b10);

        // same frame, advance toggled; start while busy ignored
        step(1'b1, 1'b0, 1'b0, 13'd4, 13'd3, 24'd8, 24'h100);
        for (int i = 0; i < 24; i++) begin
            step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 13'd2, 13'd0, 24'd3, 24'h55);
        end

        // rejected configurations
        step(1'b1, 1'b0, 1'b0, 13'd0, 13'd3, 24'd8, 24'h100);
        step(1'b0, 1'b1, 1'b0, 13'd0, 13'd3, 24'd8, 24'h100);
        step(1'b1, 1'b0, 1'b0, 13'd4, 13'd0, 24'd8, 24'h100);
        step(1'b0, 1'b0, 1'b0, 13'd4, 13'd0, 24'd8, 24'h100);

        // 1x1 frame with restart in the done cycle
        step(1'b1, 1'b0, 1'b0, 13'd1, 13'd1, 24'd0, 24'h42);
        step(1'b0, 1'b1, 1'b0, 13'd1, 13'd1, 24'd0, 24'h42);
        check_eq("one_px_done", 32'({row_done, frame_done, busy}), 32'b110);
        step(1'b1, 1'b0, 1'b0, 13'd1, 13'd1, 24'd0, 24'h77);
        check_eq("one_px_restart_addr", 32'(addr), 32'h77);
        step(1'b0, 1'b1, 1'b0, 13'd1, 13'd1, 24'd0, 24'h77);

        // clear at col=2,row=1
        step(1'b1, 1'b0, 1'b0, 13'd4, 13'd3, 24'd8, 24'h200);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 13'd4, 13'd3, 24'd8, 24'h200);
        check_eq("pre_clear_pos", 32'({col, row}), 32'({13'd2, 13'd1}));
        step(1'b0, 1'b1, 1'b1, 13'd4, 13'd3, 24'd8, 24'h200);
        check_all_zero("clear");

        // async reset mid-frame, then address wrap
        step(1'b1, 1'b0, 1'b0, 13'd4, 13'd2, 24'd16, 24'h300);
        step(1'b0, 1'b1, 1'b0, 13'd4, 13'd2, 24'd16, 24'h300);
        step(1'b0, 1'b1, 1'b0, 13'd4, 13'd2, 24'd16, 24'h300);
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        m_busy = 1'b0; m_col = '0; m_row = '0; m_rd = 1'b0; m_fd = 1'b0; m_err = 1'b0;
        m_w = '0; m_h = '0; m_p = '0; m_b = '0;
        @(negedge clk);
        n_rst = 1'b1;
        step(1'b1, 1'b0, 1'b0, 13'd4, 13'd2, 24'd4, 24'hFFFFFE);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 13'd4, 13'd2, 24'd4, 24'hFFFFFE);
        check_eq("addr_wrap", 32'(addr), 32'h000001);

        // random mix of control traffic
        for (int i = 0; i < 80; i++) begin
            step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 13'($urandom_range(0, 3)), 13'($urandom_range(0, 3)),
                 24'($urandom), 24'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_j_frame_scan_counter
